// File: rtl/ex_pkg.sv
// Shared encodings, FSM state type and op-class helpers for the execute stage.
// EX_DIV_EN adds the DIV state; without it only IDLE and MUL exist.
package ex_pkg;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SLL   = 5'd5;
   localparam logic [4:0] OP_SRL   = 5'd6;
   localparam logic [4:0] OP_SRA   = 5'd7;
   localparam logic [4:0] OP_SLT   = 5'd8;
   localparam logic [4:0] OP_SLTU  = 5'd9;
   localparam logic [4:0] OP_MUL   = 5'd10;
   localparam logic [4:0] OP_MULH  = 5'd11;
   localparam logic [4:0] OP_MULHU = 5'd12;
   localparam logic [4:0] OP_DIV   = 5'd13;
   localparam logic [4:0] OP_DIVU  = 5'd14;
   localparam logic [4:0] OP_REM   = 5'd15;
   localparam logic [4:0] OP_REMU  = 5'd16;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_EQ   = 2'd1;
   localparam logic [1:0] BR_NE   = 2'd2;
   localparam logic [1:0] BR_LT   = 2'd3;

   localparam logic B_SEL_RD2 = 1'b0;
   localparam logic B_SEL_EXT = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1
`ifdef EX_DIV_EN
      , DIV = 2'd2
`endif
   } ex_state_e;

   function automatic logic is_mul(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes.
// The divider datapath exists only when EX_DIV_EN is defined.
module ex_mdu_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic            run_i,
   input  logic            div_i,
   input  logic            neg_i,
   input  logic            hi_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] res_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q, hi_q;

   // acc holds {partial product high, remaining multiplier bits}
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step, mul_prod;
   logic [XLEN-1:0]   mul_pick;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opb_q};
   assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_prod = neg_q ? -mul_step : mul_step;
   assign mul_pick = hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

`ifdef EX_DIV_EN
   // acc holds {partial remainder, dividend bits shifting into quotient}
   logic              div_q;
   logic [XLEN:0]     div_shift, div_diff;
   logic [2*XLEN-1:0] div_step;
   logic [XLEN-1:0]   div_pick;

   assign div_shift = acc_q[2*XLEN-1:XLEN-1];
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign div_pick  = hi_q ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
   assign acc_d     = div_q ? div_step : mul_step;
   assign res_o     = div_q ? (neg_q ? -div_pick : div_pick) : mul_pick;
`else
   assign acc_d     = mul_step;
   assign res_o     = mul_pick;
`endif

   assign done_o = run_i && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         opb_q <= '0;
         cnt_q <= '0;
         neg_q <= 1'b0;
         hi_q  <= 1'b0;
`ifdef EX_DIV_EN
         div_q <= 1'b0;
`endif
      end else if (flush_i) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start_i) begin
         acc_q <= {{XLEN{1'b0}}, (div_i ? a_i : b_i)};
         opb_q <= div_i ? b_i : a_i;
         cnt_q <= CNT_LAST;
         neg_q <= neg_i;
         hi_q  <= hi_i;
`ifdef EX_DIV_EN
         div_q <= div_i;
`endif
      end else if (run_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/ex_unit_mc.sv
// Multi-cycle execute stage: ALU/branch flag in one cycle, iterative MUL/DIV via ex_mdu_iter.
// EX_DIV_EN builds the divider; otherwise DIV-class ops retire as illegal in one cycle.
//
// state | meaning
// IDLE  | accepting ops; single-cycle results written here
// MUL   | multiplier iterating, one product bit per cycle
// DIV   | divider iterating, one quotient bit per cycle (EX_DIV_EN only)
module ex_unit_mc
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_op,
   input  logic            b_sel,
   input  logic [1:0]      br_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] sext_ext,
   input  logic [XLEN-1:0] rf_rd2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] c,
   output logic            f,
   output logic            op_illegal,
   output logic            busy
);

   ex_state_e       state_q;
   logic            out_valid_q, f_q, ill_q, busy_q;
   logic [XLEN-1:0] c_q;

   logic [XLEN-1:0]    b_opnd, alu_res, a_mag, b_mag, mdu_res;
   logic [SHAMT_W-1:0] shamt;
   logic               alu_ill, alu_f, accept, is_signed, is_rem, a_neg, b_neg;
   logic               mdu_start, mdu_done, mdu_hi, mdu_neg;

   assign b_opnd   = (b_sel == B_SEL_EXT) ? sext_ext : rf_rd2;
   assign shamt    = b_opnd[SHAMT_W-1:0];
   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (alu_op)
         OP_ADD:  alu_res = a + b_opnd;
         OP_SUB:  alu_res = a - b_opnd;
         OP_AND:  alu_res = a & b_opnd;
         OP_OR:   alu_res = a | b_opnd;
         OP_XOR:  alu_res = a ^ b_opnd;
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b_opnd)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b_opnd};
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      alu_f = 1'b0;
      case (br_op)
         BR_EQ:   alu_f = (alu_res == '0);
         BR_NE:   alu_f = (alu_res != '0);
         BR_LT:   alu_f = alu_res[0];
         default: alu_f = 1'b0;
      endcase
      if (alu_ill) alu_f = 1'b0;
   end

   // Signed ops iterate on magnitudes; the sign is reapplied on the final cycle
   assign is_signed = (alu_op == OP_MUL) || (alu_op == OP_MULH) ||
                      (alu_op == OP_DIV) || (alu_op == OP_REM);
   assign is_rem    = (alu_op == OP_REM) || (alu_op == OP_REMU);
   assign a_neg     = is_signed && a[XLEN-1];
   assign b_neg     = is_signed && b_opnd[XLEN-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b_opnd : b_opnd;
   assign mdu_neg   = is_rem ? a_neg : (a_neg ^ b_neg);
   assign mdu_hi    = is_rem || (alu_op == OP_MULH) || (alu_op == OP_MULHU);

`ifdef EX_DIV_EN
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] div_spec;

   assign div_zero  = (b_opnd == '0);
   assign div_ovf   = ((alu_op == OP_DIV) || (alu_op == OP_REM)) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b_opnd == '1);
   // Overflow: quotient is MIN (== a), remainder is 0
   assign div_spec  = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : a);
   assign mdu_start = accept && (is_mul(alu_op) || (is_div(alu_op) && !div_zero && !div_ovf));
`else
   assign mdu_start = accept && is_mul(alu_op);
`endif

   ex_mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .start_i (mdu_start),
      .run_i   (state_q != IDLE),
      .div_i   (is_div(alu_op)),
      .neg_i   (mdu_neg),
      .hi_i    (mdu_hi),
      .a_i     (a_mag),
      .b_i     (b_mag),
      .done_o  (mdu_done),
      .res_o   (mdu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         f_q         <= 1'b0;
         ill_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else if (flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_mul(alu_op)) begin
                     state_q <= MUL;
                     busy_q  <= 1'b1;
                  end else if (is_div(alu_op)) begin
`ifdef EX_DIV_EN
                     if (div_zero || div_ovf) begin
                        out_valid_q <= 1'b1;
                        c_q         <= div_spec;
                        f_q         <= 1'b0;
                        ill_q       <= 1'b0;
                     end else begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                     end
`else
                     out_valid_q <= 1'b1;
                     c_q         <= '0;
                     f_q         <= 1'b0;
                     ill_q       <= 1'b1;
`endif
                  end else begin
                     out_valid_q <= 1'b1;
                     c_q         <= alu_ill ? '0 : alu_res;
                     f_q         <= alu_f;
                     ill_q       <= alu_ill;
                  end
               end
            end
            default: begin
               if (mdu_done) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  c_q         <= mdu_res;
                  f_q         <= 1'b0;
                  ill_q       <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign c          = c_q;
   assign f          = f_q;
   assign op_illegal = ill_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ex_unit_mc.sv
// Scoreboard bench for ex_unit_mc: issued ops push model results, a negedge monitor pops and compares.
module tb_ex_unit_mc;
   import ex_pkg::*;

   localparam int XLEN = 32;

   logic            clk, rst_n, flush, in_valid, in_ready, b_sel, out_valid, out_ready;
   logic            f, op_illegal, busy;
   logic [4:0]      alu_op;
   logic [1:0]      br_op;
   logic [XLEN-1:0] a, sext_ext, rf_rd2, c;

   ex_unit_mc #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .b_sel(b_sel), .br_op(br_op), .a(a), .sext_ext(sext_ext),
      .rf_rd2(rf_rd2), .out_valid(out_valid), .out_ready(out_ready), .c(c), .f(f),
      .op_illegal(op_illegal), .busy(busy)
   );

   typedef struct {
      logic [31:0] c;
      logic        f;
      logic        ill;
      int          lat;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   rand_rdy = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference behaviour straight from the arithmetic definitions
   function automatic exp_t model(input logic [4:0] op, input logic [1:0] br,
                                  input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      longint      sp;
      logic [63:0] up;
      bit          alu;
      e.c = 0; e.f = 0; e.ill = 0; e.lat = 1; e.cyc = 0; alu = 1;
      case (op)
         OP_ADD:   e.c = x + y;
         OP_SUB:   e.c = x - y;
         OP_AND:   e.c = x & y;
         OP_OR:    e.c = x | y;
         OP_XOR:   e.c = x ^ y;
         OP_SLL:   e.c = x << y[4:0];
         OP_SRL:   e.c = x >> y[4:0];
         OP_SRA:   e.c = $signed(x) >>> y[4:0];
         OP_SLT:   e.c = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         OP_SLTU:  e.c = (x < y) ? 32'd1 : 32'd0;
         OP_MUL, OP_MULH: begin
            sp = longint'($signed(x)) * longint'($signed(y));
            e.c = (op == OP_MUL) ? sp[31:0] : sp[63:32];
            e.lat = XLEN + 1; alu = 0;
         end
         OP_MULHU: begin
            up = {32'd0, x} * {32'd0, y};
            e.c = up[63:32]; e.lat = XLEN + 1; alu = 0;
         end
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
            alu = 0;
`ifdef EX_DIV_EN
            if (y == 0) e.c = (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : x;
            else if ((op == OP_DIV || op == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               e.c = (op == OP_DIV) ? 32'h8000_0000 : 32'd0;
            else begin
               e.lat = XLEN + 1;
               case (op)
                  OP_DIV:  e.c = $signed(x) / $signed(y);
                  OP_REM:  e.c = $signed(x) % $signed(y);
                  OP_DIVU: e.c = x / y;
                  default: e.c = x % y;
               endcase
            end
`else
            e.ill = 1;
`endif
         end
         default: begin e.ill = 1; alu = 0; end
      endcase
      if (alu)
         case (br)
            BR_EQ:   e.f = (e.c == 0);
            BR_NE:   e.f = (e.c != 0);
            BR_LT:   e.f = e.c[0];
            default: e.f = 0;
         endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            if (!seen) chk("unexpected_output", 64'(c), 64'(0) - 1);
            seen = !out_ready;
         end else begin
            if (!seen) begin
               chk("latency_cycle", 64'(cyc), 64'(sb[0].cyc));
               seen = 1;
            end
            if (out_ready) begin
               exp_t e;
               e = sb.pop_front();
               chk("result_c", 64'(c), 64'(e.c));
               chk("result_f_ill", 64'({f, op_illegal}), 64'({e.f, e.ill}));
               seen = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic issue(input logic [4:0] op, input logic [1:0] br, input logic bs,
                        input logic [31:0] av, input logic [31:0] ext, input logic [31:0] rd2,
                        input bit push);
      exp_t e;
      int   n = 0;
      alu_op = op; br_op = br; b_sel = bs; a = av; sext_ext = ext; rf_rd2 = rd2;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         step();
         n++;
         if (n > 200) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
         end
      end
      e = model(op, br, av, (bs == B_SEL_EXT) ? ext : rd2);
      e.cyc = cyc + e.lat;
      if (push) sb.push_back(e);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         step();
         n++;
      end
      chk("drain_pending", 64'(sb.size()), 64'(0));
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int busy_n, nrdy_n;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = OP_ADD; br_op = BR_NONE; b_sel = B_SEL_RD2; a = 0; sext_ext = 0; rf_rd2 = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_c", 64'(c), 64'(0));
      chk("rst_f_ill", 64'({f, op_illegal}), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      step();

      issue(OP_ADD, BR_NONE, B_SEL_EXT, 32'd5, 32'hFFFF_FFFD, 32'd0, 1);
      issue(OP_SUB, BR_EQ, B_SEL_RD2, 32'd7, 32'd0, 32'd7, 1);
      issue(OP_SUB, BR_EQ, B_SEL_RD2, 32'd8, 32'd0, 32'd7, 1);
      issue(OP_SLT, BR_LT, B_SEL_EXT, 32'hFFFF_FFF0, 32'd3, 32'd0, 1);
      issue(OP_SRA, BR_NE, B_SEL_RD2, 32'h8000_0000, 32'd0, 32'h0000_0124, 1);
      issue(5'd21, BR_EQ, B_SEL_RD2, 32'd3, 32'd0, 32'd3, 1);
      drain();

      issue(OP_MULH, BR_EQ, B_SEL_RD2, 32'h8000_0000, 32'd0, 32'd2, 1);
      busy_n = 0; nrdy_n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) break;
         if (busy) busy_n++;
         if (!in_ready) nrdy_n++;
         step();
      end
      chk("mul_busy_cycles", 64'(busy_n), 64'(32));
      chk("mul_stall_cycles", 64'(nrdy_n), 64'(32));
      drain();

      issue(OP_DIV,  BR_NONE, B_SEL_EXT, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
      issue(OP_REM,  BR_NONE, B_SEL_EXT, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
      issue(OP_DIVU, BR_NONE, B_SEL_RD2, 32'd1234, 32'd9, 32'd0, 1);
      issue(OP_REMU, BR_NONE, B_SEL_RD2, 32'd1234, 32'd9, 32'd0, 1);
      issue(OP_DIV,  BR_NONE, B_SEL_RD2, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1);
      issue(OP_REM,  BR_NONE, B_SEL_RD2, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1);
      issue(OP_MULHU, BR_NONE, B_SEL_RD2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1);
      drain();

      out_ready = 1'b0;
      issue(OP_SLTU, BR_NONE, B_SEL_RD2, 32'd1, 32'd0, 32'd2, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("hold_c", 64'(c), 64'(1));
         chk("hold_valid_stall", 64'({out_valid, in_ready}), 64'(2'b10));
         step();
      end
      out_ready = 1'b1;
      drain();

      issue(OP_MUL, BR_NONE, B_SEL_RD2, 32'd77, 32'd0, 32'd91, 0);
      repeat (9) step();
      flush = 1'b1;
      in_valid = 1'b1; alu_op = OP_ADD; a = 32'd1; rf_rd2 = 32'd1;
      @(negedge clk);
      chk("flush_blocks_ready", 64'(in_ready), 64'(0));
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_state", 64'({out_valid, in_ready, busy}), 64'(3'b010));
      repeat (40) step();

      issue(OP_ADD, BR_NONE, B_SEL_RD2, 32'd5, 32'd0, 32'd6, 1);
      drain();
`ifdef EX_DIV_EN
      issue(OP_DIV, BR_NONE, B_SEL_RD2, 32'd100, 32'd0, 32'd7, 0);
`else
      issue(OP_MUL, BR_NONE, B_SEL_RD2, 32'd100, 32'd0, 32'd7, 0);
`endif
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 64'({out_valid, f, op_illegal, busy}), 64'(0));
      chk("async_rst_c", 64'(c), 64'(0));
      step();
      rst_n = 1'b1;
      step();

      rand_rdy = 1;
      for (int i = 0; i < 200; i++) begin
         logic [4:0]  op;
         logic [31:0] bv;
         logic        bs;
         op = 5'($urandom_range(0, 17));
         if ($urandom_range(0, 19) == 0) op = 5'd31;
         bv = rnd_opnd();
         bs = 1'($urandom_range(0, 1));
         if (bs == B_SEL_EXT)
            issue(op, 2'($urandom_range(0, 3)), bs, rnd_opnd(), bv, $urandom(), 1);
         else
            issue(op, 2'($urandom_range(0, 3)), bs, rnd_opnd(), $urandom(), bv, 1);
         repeat ($urandom_range(0, 2)) step();
      end
      rand_rdy = 0;
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
